icache_fill_arb: RTL

ICACHE_FILL_ARB -- requirements
Module: icache_fill_arb

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fill_rr_pick.sv | 11 +
 rtl/icache_fill_arb.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-side types and constants for the I$ fill path
package fetch_pkg;
  localparam int LINE_W = 28;
  localparam logic [3:0] MEM_DEST_DEF = 4'd10;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SEND, S_WAIT, S_DONE} fill_state_t;
endpackage

// File: rtl/fill_rr_pick.sv
// fill_rr_pick: two-way round-robin pick; a lone request always wins, a tie goes to the bank not last served
module fill_rr_pick (
  input  logic req_e,
  input  logic req_o,
  input  logic last_odd,
  output logic grant_odd,
  output logic valid
);
  assign valid = req_e | req_o;
  assign grant_odd = req_o & (~req_e | ~last_odd);
endmodule

// File: rtl/icache_fill_arb.sv
// icache_fill_arb: arbitrates even/odd I$ miss fills onto the serializer bus; ICACHE_FILL_TIMEOUT_EN adds a fill watchdog
module icache_fill_arb
  import fetch_pkg::*;
#(
  parameter logic [3:0] MEM_DEST = MEM_DEST_DEF,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic miss_e,
  input  logic miss_o,
  input  logic [LINE_W-1:0] addr_e,
  input  logic [LINE_W-1:0] addr_o,
  input  logic resteer,
  input  logic ser_grant,
  input  logic ser_ack,
  input  logic des_receiver,
  output logic ser_req,
  output logic ser_release,
  output logic [3:0] ser_dest,
  output logic [31:0] ser_addr,
  output logic des_free,
  output logic fill_done_e,
  output logic fill_done_o,
  output logic fill_sel_odd,
  output logic busy,
  output logic fill_err
);
  fill_state_t state, state_n;
  logic [LINE_W-1:0] addr_q;
  logic owner, last_odd, pick_odd, pick_valid, timeout, on_bus;

  fill_rr_pick u_pick (
    .req_e(miss_e),
    .req_o(miss_o),
    .last_odd(last_odd),
    .grant_odd(pick_odd),
    .valid(pick_valid)
  );

`ifdef ICACHE_FILL_TIMEOUT_EN
  logic [7:0] cnt;
  logic active;
  assign active = state == S_REQ || state == S_SEND || state == S_WAIT;
  assign timeout = active && cnt == TIMEOUT_CYC;
  // watchdog counts cycles spent in one waiting state, restarting on every transition
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= (state_n != state || !active) ? 8'd0 : cnt + 8'd1;
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYC == 8'd0);
`endif

  // next-state logic; a watchdog expiry overrides every handshake
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = (pick_valid && !resteer) ? S_REQ : S_IDLE;
      S_REQ:  state_n = timeout ? S_IDLE : ser_grant ? S_SEND : resteer ? S_IDLE : S_REQ;
      S_SEND: state_n = timeout ? S_IDLE : ser_ack ? S_WAIT : S_SEND;
      S_WAIT: state_n = timeout ? S_IDLE : des_receiver ? S_DONE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end

  // latch the winner when a fill starts; the round-robin flag only moves when a fill really completes
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      owner <= 1'b0;
      last_odd <= 1'b1;
    end else begin
      if (state == S_IDLE && state_n == S_REQ) begin
        addr_q <= pick_odd ? addr_o : addr_e;
        owner <= pick_odd;
      end
      if (state == S_WAIT && state_n == S_DONE) last_odd <= owner;
    end
  end

  assign on_bus = !reset && (state == S_REQ || state == S_SEND);
  assign ser_req = on_bus;
  assign ser_dest = on_bus ? MEM_DEST : 4'd0;
  assign ser_addr = on_bus ? {addr_q, 4'b0} : 32'd0;
  assign ser_release = !reset && ((state == S_SEND && ser_ack) || (timeout && (state == S_SEND || state == S_WAIT)));
  assign des_free = !reset && state == S_DONE;
  assign fill_done_e = des_free && !owner;
  assign fill_done_o = des_free && owner;
  assign fill_sel_odd = !reset && owner;
  assign busy = !reset && state != S_IDLE;
  assign fill_err = !reset && timeout;
endmodule
